// File: rtl/powerup_ctrl_if.sv
// Brick/paddle inputs and capsule/power-up outputs of the power-up capsule controller.
// Latency: n/a (signal bundle only).
// Backpressure: none; every field is a per-frame level or pulse.
//
// Ports (as seen from the controller, modport slave):
//   in : brickHit, brickX, brickY, paddleX1, paddleY1, paddleSize, levelChange, noMore
//   out: capActive, capX, capY, capType, PowOn, PaddleSizeUpPow, PaddleSizeDownPow, powTimer
interface powerup_ctrl_if;
    logic       brickHit;
    logic [9:0] brickX;
    logic [9:0] brickY;
    logic [9:0] paddleX1;
    logic [9:0] paddleY1;
    logic [9:0] paddleSize;
    logic       levelChange;
    logic       noMore;

    logic       capActive;
    logic [9:0] capX;
    logic [9:0] capY;
    logic       capType;
    logic       PowOn;
    logic       PaddleSizeUpPow;
    logic       PaddleSizeDownPow;
    logic [9:0] powTimer;

    // Game side: drives brick/paddle/control, observes the capsule and power-up.
    modport master (
        output brickHit, brickX, brickY, paddleX1, paddleY1, paddleSize,
               levelChange, noMore,
        input  capActive, capX, capY, capType, PowOn,
               PaddleSizeUpPow, PaddleSizeDownPow, powTimer
    );

    // Controller side.
    modport slave (
        input  brickHit, brickX, brickY, paddleX1, paddleY1, paddleSize,
               levelChange, noMore,
        output capActive, capX, capY, capType, PowOn,
               PaddleSizeUpPow, PaddleSizeDownPow, powTimer
    );
endinterface

// File: rtl/powerup_ctrl.sv
// Power-up capsule controller: spawns a capsule every SPAWN_EVERY brick hits, drops it,
// detects a paddle catch and drives the paddle's power-up inputs for POW_FRAMES frames.
// Latency: all outputs registered, update on the frame edge that samples the cause.
// Backpressure: none; noMore freezes capsule motion, timer and state (hit counter keeps counting).
//
// Ports: frame_clk, Reset (async, active-high) plus powerup_ctrl_if.slave:
//   in : brickHit/brickX/brickY, paddleX1/paddleY1/paddleSize, levelChange, noMore
//   out: capActive/capX/capY/capType, PowOn, PaddleSizeUpPow/PaddleSizeDownPow, powTimer
module powerup_ctrl #(
    parameter int SPAWN_EVERY = 4,
    parameter int FALL_STEP   = 2,
    parameter int CAP_W       = 16,
    parameter int CAP_H       = 8,
    parameter int PADDLE_H    = 6,
    parameter int CAP_Y_MAX   = 471,
    parameter int POW_FRAMES  = 600
) (
    input  logic          frame_clk,
    input  logic          Reset,
    powerup_ctrl_if.slave pu
);

    localparam int CNT_W = (SPAWN_EVERY > 1) ? $clog2(SPAWN_EVERY) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FALL   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t     state,      state_nxt;
    logic [CNT_W-1:0] hit_cnt, hit_cnt_nxt;
    logic       type_sel,   type_sel_nxt;
    logic       cap_active, cap_active_nxt;
    logic [9:0] cap_x,      cap_x_nxt;
    logic [9:0] cap_y,      cap_y_nxt;
    logic       cap_type,   cap_type_nxt;
    logic       pow_on,     pow_on_nxt;
    logic       pow_up,     pow_up_nxt;
    logic       pow_dn,     pow_dn_nxt;
    logic [9:0] pow_timer,  pow_timer_nxt;

    logic       spawn_hit;
    logic       catch_hit;
    logic       miss_line;
    logic [10:0] cap_bot;
    logic [10:0] cap_rgt;
    logic [10:0] pad_bot;
    logic [10:0] pad_rgt;

    // Bounding boxes are compared in 11 bits so edge sums near 1023 never wrap.
    always_comb begin
        cap_bot   = {1'b0, cap_y} + 11'(CAP_H);
        cap_rgt   = {1'b0, cap_x} + 11'(CAP_W);
        pad_bot   = {1'b0, pu.paddleY1} + 11'(PADDLE_H);
        pad_rgt   = {1'b0, pu.paddleX1} + {1'b0, pu.paddleSize};
        catch_hit = (cap_bot >= {1'b0, pu.paddleY1}) &&
                    ({1'b0, cap_y} <= pad_bot) &&
                    (cap_rgt > {1'b0, pu.paddleX1}) &&
                    ({1'b0, cap_x} < pad_rgt);
        miss_line = ({1'b0, cap_y} >= 11'(CAP_Y_MAX));
        spawn_hit = pu.brickHit && (hit_cnt == CNT_W'(SPAWN_EVERY - 1));
    end

    always_comb begin
        state_nxt      = state;
        hit_cnt_nxt    = hit_cnt;
        type_sel_nxt   = type_sel;
        cap_active_nxt = cap_active;
        cap_x_nxt      = cap_x;
        cap_y_nxt      = cap_y;
        cap_type_nxt   = cap_type;
        pow_on_nxt     = pow_on;
        pow_up_nxt     = pow_up;
        pow_dn_nxt     = pow_dn;
        pow_timer_nxt  = pow_timer;

        // Hits are counted in every state, frozen or not; spawn hits outside IDLE are lost.
        if (pu.brickHit) begin
            hit_cnt_nxt = spawn_hit ? '0 : hit_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (spawn_hit && !pu.noMore) begin
                    state_nxt      = FALL;
                    cap_active_nxt = 1'b1;
                    cap_x_nxt      = pu.brickX;
                    cap_y_nxt      = pu.brickY;
                    cap_type_nxt   = type_sel;
                    type_sel_nxt   = ~type_sel;
                end
            end
            FALL: begin
                if (!pu.noMore) begin
                    // Catch is tested before the miss line so a catch on the last row wins.
                    if (catch_hit) begin
                        state_nxt      = ACTIVE;
                        cap_active_nxt = 1'b0;
                        pow_on_nxt     = 1'b1;
                        pow_up_nxt     = ~cap_type;
                        pow_dn_nxt     = cap_type;
                        pow_timer_nxt  = 10'(POW_FRAMES - 1);
                    end else if (miss_line) begin
                        state_nxt      = IDLE;
                        cap_active_nxt = 1'b0;
                    end else begin
                        cap_y_nxt      = cap_y + 10'(FALL_STEP);
                    end
                end
            end
            ACTIVE: begin
                if (!pu.noMore) begin
                    if (pow_timer == 10'd0) begin
                        state_nxt  = IDLE;
                        pow_on_nxt = 1'b0;
                        pow_up_nxt = 1'b0;
                        pow_dn_nxt = 1'b0;
                    end else begin
                        pow_timer_nxt = pow_timer - 10'd1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Level change wipes everything, including a hit arriving in the same frame.
        if (pu.levelChange) begin
            state_nxt      = IDLE;
            hit_cnt_nxt    = '0;
            type_sel_nxt   = 1'b0;
            cap_active_nxt = 1'b0;
            cap_x_nxt      = '0;
            cap_y_nxt      = '0;
            cap_type_nxt   = 1'b0;
            pow_on_nxt     = 1'b0;
            pow_up_nxt     = 1'b0;
            pow_dn_nxt     = 1'b0;
            pow_timer_nxt  = '0;
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            hit_cnt    <= '0;
            type_sel   <= 1'b0;
            cap_active <= 1'b0;
            cap_x      <= '0;
            cap_y      <= '0;
            cap_type   <= 1'b0;
            pow_on     <= 1'b0;
            pow_up     <= 1'b0;
            pow_dn     <= 1'b0;
            pow_timer  <= '0;
        end else begin
            state      <= state_nxt;
            hit_cnt    <= hit_cnt_nxt;
            type_sel   <= type_sel_nxt;
            cap_active <= cap_active_nxt;
            cap_x      <= cap_x_nxt;
            cap_y      <= cap_y_nxt;
            cap_type   <= cap_type_nxt;
            pow_on     <= pow_on_nxt;
            pow_up     <= pow_up_nxt;
            pow_dn     <= pow_dn_nxt;
            pow_timer  <= pow_timer_nxt;
        end
    end

    assign pu.capActive         = cap_active;
    assign pu.capX              = cap_x;
    assign pu.capY              = cap_y;
    assign pu.capType           = cap_type;
    assign pu.PowOn             = pow_on;
    assign pu.PaddleSizeUpPow   = pow_up;
    assign pu.PaddleSizeDownPow = pow_dn;
    assign pu.powTimer          = pow_timer;

endmodule

// File: tb/tb_powerup_ctrl.sv
// Scoreboard bench: each stimulus frame runs a behavioural game model and queues the expected
// outputs; a monitor pops one entry per DUT edge (clock or async reset) and compares.
module tb_powerup_ctrl;

    localparam int SPAWN_EVERY = 4;
    localparam int FALL_STEP   = 2;
    localparam int CAP_W       = 16;
    localparam int CAP_H       = 8;
    localparam int PADDLE_H    = 6;
    localparam int CAP_Y_MAX   = 471;
    localparam int POW_FRAMES  = 600;

    typedef struct packed {
        logic       cap_active;
        logic [9:0] cap_x;
        logic [9:0] cap_y;
        logic       cap_type;
        logic       pow_on;
        logic       up;
        logic       dn;
        logic [9:0] pow_timer;
    } obs_t;

    logic frame_clk = 1'b0;
    logic Reset;
    powerup_ctrl_if pif();

    powerup_ctrl #(
        .SPAWN_EVERY (SPAWN_EVERY),
        .FALL_STEP   (FALL_STEP),
        .CAP_W       (CAP_W),
        .CAP_H       (CAP_H),
        .PADDLE_H    (PADDLE_H),
        .CAP_Y_MAX   (CAP_Y_MAX),
        .POW_FRAMES  (POW_FRAMES)
    ) dut (
        .frame_clk (frame_clk),
        .Reset     (Reset),
        .pu        (pif.slave)
    );

    always #5 frame_clk = ~frame_clk;

    int   checks = 0;
    int   errors = 0;
    int   pow_hi = 0;
    obs_t exp_q[$];

    // Current brick/paddle inputs applied by tick().
    int g_bx, g_by, g_px, g_py, g_psz;

    // Reference model: game-level view (mode, total hits, capsules spawned so far).
    localparam int M_IDLE = 0, M_FALL = 1, M_ACTIVE = 2;
    int m_mode, m_hits, m_spawns, m_cx, m_cy, m_ct, m_timer;

    task automatic model_clear();
        m_mode = M_IDLE; m_hits = 0; m_spawns = 0;
        m_cx = 0; m_cy = 0; m_ct = 0; m_timer = 0;
    endtask

    task automatic model_step(input bit hit, input bit lc, input bit nm);
        bit spawn;
        bit caught;
        if (lc) begin
            model_clear();
            return;
        end
        spawn = hit && (((m_hits + 1) % SPAWN_EVERY) == 0);
        if (hit) m_hits++;
        case (m_mode)
            M_IDLE: if (spawn && !nm) begin
                m_mode = M_FALL;
                m_cx = g_bx; m_cy = g_by;
                m_ct = m_spawns % 2;     // grow, shrink, grow, ...
                m_spawns++;
            end
            M_FALL: if (!nm) begin
                caught = (m_cy + CAP_H >= g_py) && (m_cy <= g_py + PADDLE_H) &&
                         (m_cx + CAP_W > g_px) && (m_cx < g_px + g_psz);
                if (caught) begin
                    m_mode = M_ACTIVE; m_timer = POW_FRAMES - 1;
                end else if (m_cy >= CAP_Y_MAX) begin
                    m_mode = M_IDLE;
                end else begin
                    m_cy = m_cy + FALL_STEP;
                end
            end
            default: if (!nm) begin
                if (m_timer == 0) m_mode = M_IDLE;
                else m_timer--;
            end
        endcase
    endtask

    function automatic obs_t model_obs();
        obs_t o;
        o.cap_active = (m_mode == M_FALL);
        o.cap_x      = 10'(m_cx);
        o.cap_y      = 10'(m_cy);
        o.cap_type   = m_ct[0];
        o.pow_on     = (m_mode == M_ACTIVE);
        o.up         = (m_mode == M_ACTIVE) && (m_ct == 0);
        o.dn         = (m_mode == M_ACTIVE) && (m_ct == 1);
        o.pow_timer  = (m_mode == M_ACTIVE) ? 10'(m_timer) : 10'd0;
        return o;
    endfunction

    function automatic obs_t dut_obs();
        obs_t o;
        o.cap_active = pif.capActive;
        o.cap_x      = pif.capX;
        o.cap_y      = pif.capY;
        o.cap_type   = pif.capType;
        o.pow_on     = pif.PowOn;
        o.up         = pif.PaddleSizeUpPow;
        o.dn         = pif.PaddleSizeDownPow;
        o.pow_timer  = pif.powTimer;
        return o;
    endfunction

    // Monitor: one expected entry per DUT event.
    initial begin
        obs_t a, e;
        forever begin
            @(posedge frame_clk or posedge Reset);
            #1;
            a = dut_obs();
            if (frame_clk && a.pow_on) pow_hi++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL frame_out @%0t actual act=%0b x=%0d y=%0d typ=%0b pow=%0b up=%0b dn=%0b tmr=%0d required act=%0b x=%0d y=%0d typ=%0b pow=%0b up=%0b dn=%0b tmr=%0d",
                             $time, a.cap_active, a.cap_x, a.cap_y, a.cap_type, a.pow_on, a.up, a.dn, a.pow_timer,
                             e.cap_active, e.cap_x, e.cap_y, e.cap_type, e.pow_on, e.up, e.dn, e.pow_timer);
                end
            end
        end
    end

    task automatic tick(input bit hit, input bit lc, input bit nm);
        @(negedge frame_clk);
        pif.brickHit    = hit;
        pif.brickX      = 10'(g_bx);
        pif.brickY      = 10'(g_by);
        pif.paddleX1    = 10'(g_px);
        pif.paddleY1    = 10'(g_py);
        pif.paddleSize  = 10'(g_psz);
        pif.levelChange = lc;
        pif.noMore      = nm;
        model_step(hit, lc, nm);
        exp_q.push_back(model_obs());
    endtask

    task automatic hit_gap();
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_mode(input int mode, input int budget);
        int n = 0;
        while (m_mode != mode && n < budget) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        checks++;
        if (m_mode != mode) begin
            errors++;
            $display("FAIL mode_wait actual mode=%0d required mode=%0d within %0d frames", m_mode, mode, budget);
        end
    endtask

    // Reset pulse placed between clock edges so the outputs must clear asynchronously.
    task automatic async_reset();
        @(negedge frame_clk);
        #1;
        model_clear();
        exp_q.push_back(model_obs());
        Reset = 1'b1;
        #2;
        Reset = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired with %0d expected entries pending", exp_q.size());
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        Reset = 1'b0;
        g_bx = 300; g_by = 100; g_px = 8; g_py = 465; g_psz = 75;
        pif.brickHit = 1'b0; pif.brickX = '0; pif.brickY = '0;
        pif.paddleX1 = '0; pif.paddleY1 = '0; pif.paddleSize = '0;
        pif.levelChange = 1'b0; pif.noMore = 1'b0;
        model_clear();
        #1;
        exp_q.push_back(model_obs());
        Reset = 1'b1;
        #2;
        Reset = 1'b0;

        // Spawn on the 4th hit, hits during the fall are ignored, capsule misses a far paddle.
        repeat (4) hit_gap();
        repeat (4) hit_gap();
        run_mode(M_IDLE, 400);
        repeat (3) tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);

        // Catch with freezes in both FALL and ACTIVE; PowOn must last POW_FRAMES + 10 frames.
        pow_hi = 0;
        g_px = 280;
        repeat (4) hit_gap();
        repeat (50) tick(1'b0, 1'b0, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 1'b1);
        run_mode(M_ACTIVE, 400);
        repeat (100) tick(1'b0, 1'b0, 1'b0);
        repeat (10) tick(1'b0, 1'b0, 1'b1);
        run_mode(M_IDLE, 700);
        repeat (2) tick(1'b0, 1'b0, 1'b0);
        checks++;
        if (pow_hi != POW_FRAMES + 10) begin
            errors++;
            $display("FAIL pow_duration actual %0d frames required %0d", pow_hi, POW_FRAMES + 10);
        end

        // Second capsule is a shrink; level change mid-power-up, then 3 hits must not spawn.
        repeat (4) hit_gap();
        run_mode(M_ACTIVE, 400);
        n = 0;
        while (m_timer != 300 && n < 700) begin
            tick(1'b0, 1'b0, 1'b0);
            n++;
        end
        tick(1'b1, 1'b1, 1'b0);
        repeat (3) hit_gap();
        repeat (3) tick(1'b0, 1'b0, 1'b0);

        // Async reset while a capsule is falling.
        hit_gap();
        repeat (20) tick(1'b0, 1'b0, 1'b0);
        async_reset();
        repeat (3) tick(1'b0, 1'b0, 1'b0);

        // Randomized play.
        for (int i = 0; i < 4000; i++) begin
            if (i % 64 == 0) begin
                g_px  = int'($urandom_range(0, 560));
                g_py  = int'($urandom_range(380, 470));
                g_psz = int'($urandom_range(30, 120));
            end
            g_bx = int'($urandom_range(0, 620));
            g_by = int'($urandom_range(0, 470));
            tick($urandom_range(0, 7) == 0, $urandom_range(0, 999) == 0, $urandom_range(0, 31) == 0);
        end

        repeat (2) @(negedge frame_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain actual %0d pending required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/powerup_ctrl.md
# powerup_ctrl

Power-up capsule controller for the brick-breaker game, sitting directly upstream of the paddle block. On every SPAWN_EVERY-th brick hit it drops a capsule from the hit brick's position. It tests each frame for a catch against the paddle's current position and size. On a catch it drives the paddle's PowOn / PaddleSizeUpPow / PaddleSizeDownPow inputs for a fixed number of frames.

## Interface

Clocking and reset (already decided):
- One clock, frame_clk.
- Reset is asynchronous and active-high, named Reset.

Parameters:
- SPAWN_EVERY, default 4: brick hits per capsule spawn.
- FALL_STEP, default 2: capsule Y pixels per frame.
- CAP_W, default 16: capsule width in pixels.
- CAP_H, default 8: capsule height in pixels.
- PADDLE_H, default 6: paddle hit height in pixels.
- CAP_Y_MAX, default 471: miss line (top-of-capsule Y).
- POW_FRAMES, default 600: power-up duration in frames.

Ports:
- Reset  in  1  async active-high reset.
- frame_clk  in  1  frame clock.
- brickHit  in  1  one-frame pulse; a brick was destroyed this frame.
- brickX, brickY  in  10  top-left of the destroyed brick, valid with brickHit.
- paddleX1, paddleY1, paddleSize  in  10  from the paddle block.
- levelChange  in  1  synchronous clear.
- noMore  in  1  game frozen.
- capActive  out  1  capsule falling (for drawing).
- capX, capY  out  10  capsule top-left.
- capType  out  1  0 = grow, 1 = shrink.
- PowOn  out  1  power-up in effect.
- PaddleSizeUpPow, PaddleSizeDownPow  out  1  one-hot while PowOn, both 0 otherwise.
- powTimer  out  10  frames remaining while ACTIVE, else 0.

## Operation

- States: IDLE, FALL, ACTIVE. All outputs are registered.
- Hit counter:
  - 0..SPAWN_EVERY-1, counts brickHit in every state.
  - A hit with counter = SPAWN_EVERY-1 is a "spawn hit"; the counter wraps to 0.
- IDLE -> FALL on a spawn hit:
  - capX <= brickX, capY <= brickY, capType <= typeSel.
  - typeSel toggles on each spawn (first capsule is grow).
- Spawn hits in FALL or ACTIVE are discarded. The counter still wraps and typeSel does not toggle.
- FALL, each frame with noMore = 0:
  - Catch = (capY+CAP_H >= paddleY1) && (capY <= paddleY1+PADDLE_H) && (capX+CAP_W > paddleX1) && (capX < paddleX1+paddleSize).
  - All sums are computed in 11 bits; no wrap.
  - Catch -> ACTIVE: PowOn <= 1, Up/Down <= capType decode, powTimer <= POW_FRAMES-1, capActive <= 0.
  - Else if capY >= CAP_Y_MAX -> IDLE, capActive <= 0 (miss).
  - Else capY <= capY + FALL_STEP.
  - Catch wins over miss in the same frame.
- ACTIVE, each frame with noMore = 0:
  - powTimer = 0 -> IDLE: PowOn, Up and Down all <= 0.
  - Else powTimer decrements.
- noMore = 1: capY, powTimer and state hold. The hit counter still counts.
- levelChange = 1, synchronous:
  - Next state IDLE; all outputs 0.
  - Hit counter and typeSel cleared.
  - Overrides brickHit in the same frame.
- Reset: same values as levelChange, applied asynchronously.

## Timing

- Reset values: capActive = 0, capX = capY = 0, capType = 0, PowOn = 0, Up = Down = 0, powTimer = 0, state IDLE.
- Spawn: outputs update on the same edge that samples the spawn hit; capY = brickY on that edge.
- Catch: the comparator uses the registered capY. PowOn rises on the next edge.
- Duration: PowOn is high for exactly POW_FRAMES edges, excluding noMore frames.
- Paddle coupling: the paddle samples PowOn one edge later, so its size changes one frame after PowOn moves.
- Legality: Up and Down are never both 1, and neither is 1 while PowOn = 0.

## Test plan

- Spawn count: paddle stationary at X=8, Y=465, size 75; brickHit pulses at X=300, Y=100.
  - Hits 1-3 -> capActive stays 0.
  - Hit 4 -> capActive = 1, capX = 300, capY = 100, capType = 0 on that edge.
- Catch: spawn at (300,100) with paddleX1 = 280, size 75.
  - capY reaches 458 after 179 frames.
  - Next edge: PowOn = 1, PaddleSizeUpPow = 1, powTimer = 599, capActive = 0.
- Expiry: continue from the catch.
  - PowOn is high for 600 edges, then PowOn = Up = 0 and state IDLE.
  - Next capsule (hit 8) has capType = 1 and sets PaddleSizeDownPow on catch.
- Miss: spawn at (300,100) with paddle at X=8.
  - capY reaches 472 at frame 186; next edge capActive = 0, PowOn stays 0.
  - A brickHit during FALL does not respawn.
- levelChange mid-ACTIVE with powTimer = 300 -> next edge all outputs 0, and 3 further hits do not spawn.
- noMore held 10 frames during FALL and during ACTIVE -> capY and powTimer are unchanged, and total PowOn-high time is 610 frames.
- Async Reset asserted mid-FALL -> outputs go to 0 without a clock edge.
